bp_trace_monitor: RTL and testbench

Hardware responder for breakpoint-trace events emitted by instrumented RTL: each instrumented statement presents its statement ID, and this block matches it against a programmable breakpoint table plus a single-step mode. On a hit it halts the design by withholding `trace_ready` until the debugger issues a resume. It is the on-chip counterpart of the software breakpoint runtime. It sits between the instrumented design and the debug configuration/status registers.

---
 rtl/bp_trace_monitor_pkg.sv | 21 ++
 rtl/bp_trace_monitor_if.sv | 25 ++
 rtl/bp_trace_monitor_match_table.sv | 57 +++++
 rtl/bp_trace_monitor.sv | 111 +++++++++++
 tb/tb_bp_trace_monitor.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bp_trace_monitor_pkg.sv
// Shared types and constants for the breakpoint-trace monitor.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package bp_trace_pkg;

  // Why the design last halted. NONE is only seen between reset and the first halt.
  typedef enum logic [1:0] {
    NONE    = 2'd0,
    BP      = 2'd1,
    STEP    = 2'd2,
    BP_STEP = 2'd3
  } halt_cause_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [15:0] HIT_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/bp_trace_monitor_if.sv
// Trace handshake between instrumented RTL (master) and the monitor (slave).
// Latency: n/a (wires only).
// Backpressure: the slave holds trace_ready low to stall the master while halted.
// Signals: trace_valid/trace_id from master, trace_ready from slave.
interface bp_trace_monitor_if #(
  parameter int ID_WIDTH = 32
);

  logic                trace_valid;
  logic [ID_WIDTH-1:0] trace_id;
  logic                trace_ready;

  modport master (
    output trace_valid,
    output trace_id,
    input  trace_ready
  );

  modport slave (
    input  trace_valid,
    input  trace_id,
    output trace_ready
  );

endinterface

// File: rtl/bp_trace_monitor_match_table.sv
// Programmable breakpoint table: NUM_BP id/enable entries, parallel compare, lowest-index priority.
// Latency: compare is combinational on lookup_id; a write becomes visible one cycle later.
// Backpressure: none; the write port is always accepted.
// Ports: clk/rst_n, cfg_we/cfg_idx/cfg_id/cfg_en write port, lookup_id in, any_hit/hit_idx out.
module bp_match_table #(
  parameter int  ID_WIDTH = 32,
  parameter int  NUM_BP   = 8,
  localparam int IDX_W    = $clog2(NUM_BP)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [ID_WIDTH-1:0] cfg_id,
  input  logic                cfg_en,
  input  logic [ID_WIDTH-1:0] lookup_id,
  output logic                any_hit,
  output logic [IDX_W-1:0]    hit_idx
);

  logic [ID_WIDTH-1:0] bp_id [NUM_BP];
  logic [NUM_BP-1:0]   bp_en;
  logic [NUM_BP-1:0]   hit_vec;

  // Compares read the registered table, so a same-cycle write never affects the current lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BP; i++) begin
        bp_id[i] <= '0;
      end
      bp_en <= '0;
    end else if (cfg_we) begin
      bp_id[cfg_idx] <= cfg_id;
      bp_en[cfg_idx] <= cfg_en;
    end
  end

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      hit_vec[i] = bp_en[i] && (bp_id[i] == lookup_id);
    end
  end

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign any_hit = |hit_vec;

endmodule

// File: rtl/bp_trace_monitor.sv
// Breakpoint-trace responder: matches trace IDs against a breakpoint table / single-step and stalls on a hit.
// Latency: halt, capture and counters register one cycle after the accepting edge; trace_ready decodes state only.
// Backpressure: trace_ready held low from the cycle after a halting accept until the cycle after resume.
// Ports: clk/rst_n; trace (slave handshake); cfg_* table write; step_en/resume control;
//        halted/halt_id/halt_idx/halt_cause status; hit_count (saturating), trace_count (wrapping).
module bp_trace_monitor
  import bp_trace_pkg::*;
#(
  parameter int  ID_WIDTH = 32,
  parameter int  NUM_BP   = 8,
  localparam int IDX_W    = $clog2(NUM_BP)
) (
  input  logic                clk,
  input  logic                rst_n,
  bp_trace_monitor_if.slave   trace,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [ID_WIDTH-1:0] cfg_id,
  input  logic                cfg_en,
  input  logic                step_en,
  input  logic                resume,
  output logic                halted,
  output logic [ID_WIDTH-1:0] halt_id,
  output logic [IDX_W-1:0]    halt_idx,
  output logic [1:0]          halt_cause,
  output logic [15:0]         hit_count,
  output logic [31:0]         trace_count
);

  state_t              state_q;
  state_t              state_d;
  halt_cause_t         cause_q;
  logic [15:0]         hit_cnt_q;
  logic [31:0]         trace_cnt_q;
  logic                accept;
  logic                halt_now;
  logic                any_hit;
  logic [IDX_W-1:0]    hit_idx;

  bp_match_table #(
    .ID_WIDTH (ID_WIDTH),
    .NUM_BP   (NUM_BP)
  ) u_match_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_id    (cfg_id),
    .cfg_en    (cfg_en),
    .lookup_id (trace.trace_id),
    .any_hit   (any_hit),
    .hit_idx   (hit_idx)
  );

  // Ready depends only on the state register, never on the incoming trace.
  assign trace.trace_ready = (state_q == RUN);
  assign halted            = (state_q == HALT);

  assign accept   = trace.trace_valid && (state_q == RUN);
  assign halt_now = accept && (any_hit || step_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_now) state_d = HALT;
      HALT:    if (resume)   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Halt record persists through HALT and after resume until the next halting accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_id  <= '0;
      halt_idx <= '0;
      cause_q  <= NONE;
    end else if (halt_now) begin
      halt_id  <= trace.trace_id;
      halt_idx <= any_hit ? hit_idx : '0;
      cause_q  <= halt_cause_t'({step_en, any_hit});
    end
  end

  assign halt_cause = cause_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q   <= '0;
      trace_cnt_q <= '0;
    end else begin
      if (halt_now && (hit_cnt_q != HIT_COUNT_MAX)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (accept) begin
        trace_cnt_q <= trace_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count   = hit_cnt_q;
  assign trace_count = trace_cnt_q;

endmodule

// File: tb/tb_bp_trace_monitor.sv
// Directed bench for bp_trace_monitor: vector table plus hand-written multi-cycle sequences.
// Latency: inputs change 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: trace_valid is held while the monitor stalls.
module tb_bp_trace_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_id;
  logic        cfg_en;
  logic        step_en;
  logic        resume;
  logic        halted;
  logic [31:0] halt_id;
  logic [2:0]  halt_idx;
  logic [1:0]  halt_cause;
  logic [15:0] hit_count;
  logic [31:0] trace_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_hit;
  logic [31:0] exp_tc;

  bp_trace_monitor_if #(.ID_WIDTH(32)) tif ();

  bp_trace_monitor #(.ID_WIDTH(32), .NUM_BP(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trace       (tif),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_id      (cfg_id),
    .cfg_en      (cfg_en),
    .step_en     (step_en),
    .resume      (resume),
    .halted      (halted),
    .halt_id     (halt_id),
    .halt_idx    (halt_idx),
    .halt_cause  (halt_cause),
    .hit_count   (hit_count),
    .trace_count (trace_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tv;
    logic [31:0] tid;
    logic        we;
    logic [2:0]  idx;
    logic [31:0] cid;
    logic        cen;
    logic        step;
    logic        res;
    logic        e_rdy;
    logic        e_halt;
    logic [31:0] e_hid;
    logic [2:0]  e_hidx;
    logic [1:0]  e_cause;
    logic [15:0] e_hit;
    logic [31:0] e_tc;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mkv(input logic tv, input logic [31:0] tid, input logic we, input logic [2:0] idx,
                               input logic [31:0] cid, input logic cen, input logic step, input logic res,
                               input logic rdy, input logic hlt, input logic [31:0] hid, input logic [2:0] hidx,
                               input logic [1:0] cause, input logic [15:0] hit, input logic [31:0] tc);
    vec_t v;
    v.tv = tv; v.tid = tid; v.we = we; v.idx = idx; v.cid = cid; v.cen = cen; v.step = step; v.res = res;
    v.e_rdy = rdy; v.e_halt = hlt; v.e_hid = hid; v.e_hidx = hidx; v.e_cause = cause; v.e_hit = hit; v.e_tc = tc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic hlt, input logic [31:0] hid,
                         input logic [2:0] hidx, input logic [1:0] cause, input logic [15:0] hit,
                         input logic [31:0] tc);
    chk({tag, " trace_ready"}, 64'(tif.trace_ready), 64'(rdy));
    chk({tag, " halted"},      64'(halted),          64'(hlt));
    chk({tag, " halt_id"},     64'(halt_id),         64'(hid));
    chk({tag, " halt_idx"},    64'(halt_idx),        64'(hidx));
    chk({tag, " halt_cause"},  64'(halt_cause),      64'(cause));
    chk({tag, " hit_count"},   64'(hit_count),       64'(hit));
    chk({tag, " trace_count"}, 64'(trace_count),     64'(tc));
  endtask

  task automatic drive(input logic tv, input logic [31:0] tid, input logic we, input logic [2:0] idx,
                       input logic [31:0] cid, input logic cen, input logic step, input logic res);
    tif.trace_valid = tv;
    tif.trace_id    = tid;
    cfg_we          = we;
    cfg_idx         = idx;
    cfg_id          = cid;
    cfg_en          = cen;
    step_en         = step;
    resume          = res;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One step-mode halt on id, then a resume cycle; tracks expected counters.
  task automatic step_halt(input string tag, input logic [31:0] id, input logic [1:0] cause);
    drive(1'b1, id, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    exp_tc = exp_tc + 32'd1;
    if (exp_hit != 16'hFFFF) exp_hit = exp_hit + 16'd1;
    chk_all({tag, " halt"}, 1'b0, 1'b1, id, 3'd0, cause, exp_hit, exp_tc);
    // Valid stays high with a new id during the resume cycle: must not be accepted.
    drive(1'b1, id + 32'd1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_all({tag, " resume"}, 1'b1, 1'b0, id, 3'd0, cause, exp_hit, exp_tc);
  endtask

  initial begin
    //             tv  tid    we idx cid  cen st res   rdy hlt hid  hidx c  hit tc
    vecs[0]  = mkv(0, 32'h0, 1, 3, 32'h5, 1, 0, 0,   1, 0, 32'h0, 0, 0, 0, 0);
    vecs[1]  = mkv(1, 32'h1, 0, 0, 32'h0, 0, 0, 0,   1, 0, 32'h0, 0, 0, 0, 1);
    vecs[2]  = mkv(1, 32'h5, 0, 0, 32'h0, 0, 0, 0,   0, 1, 32'h5, 3, 1, 1, 2);
    vecs[3]  = mkv(1, 32'h6, 0, 0, 32'h0, 0, 0, 0,   0, 1, 32'h5, 3, 1, 1, 2);
    vecs[4]  = mkv(1, 32'h6, 0, 0, 32'h0, 0, 0, 1,   1, 0, 32'h5, 3, 1, 1, 2);
    vecs[5]  = mkv(1, 32'h6, 0, 0, 32'h0, 0, 0, 0,   1, 0, 32'h5, 3, 1, 1, 3);
    vecs[6]  = mkv(0, 32'h0, 0, 0, 32'h0, 0, 0, 0,   1, 0, 32'h5, 3, 1, 1, 3);
    vecs[7]  = mkv(0, 32'h0, 1, 1, 32'h9, 1, 0, 0,   1, 0, 32'h5, 3, 1, 1, 3);
    vecs[8]  = mkv(0, 32'h0, 1, 6, 32'h9, 1, 0, 0,   1, 0, 32'h5, 3, 1, 1, 3);
    vecs[9]  = mkv(1, 32'h9, 0, 0, 32'h0, 0, 0, 0,   0, 1, 32'h9, 1, 1, 2, 4);
    vecs[10] = mkv(0, 32'h0, 1, 1, 32'h9, 0, 0, 0,   0, 1, 32'h9, 1, 1, 2, 4);
    vecs[11] = mkv(0, 32'h0, 0, 0, 32'h0, 0, 0, 1,   1, 0, 32'h9, 1, 1, 2, 4);
    vecs[12] = mkv(1, 32'h9, 0, 0, 32'h0, 0, 0, 0,   0, 1, 32'h9, 6, 1, 3, 5);
    vecs[13] = mkv(0, 32'h0, 0, 0, 32'h0, 0, 0, 1,   1, 0, 32'h9, 6, 1, 3, 5);
    vecs[14] = mkv(1, 32'h7, 1, 2, 32'h7, 1, 0, 0,   1, 0, 32'h9, 6, 1, 3, 6);
    vecs[15] = mkv(1, 32'h7, 0, 0, 32'h0, 0, 0, 0,   0, 1, 32'h7, 2, 1, 4, 7);
    vecs[16] = mkv(0, 32'h0, 0, 0, 32'h0, 0, 0, 1,   1, 0, 32'h7, 2, 1, 4, 7);

    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("reset", 1'b1, 1'b0, 32'h0, 3'd0, 2'd0, 16'd0, 32'd0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].tv, vecs[i].tid, vecs[i].we, vecs[i].idx, vecs[i].cid, vecs[i].cen, vecs[i].step, vecs[i].res);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_halt, vecs[i].e_hid, vecs[i].e_hidx,
              vecs[i].e_cause, vecs[i].e_hit, vecs[i].e_tc);
    end

    // Single-step stream 0..4: one accepted trace and one halt per resume.
    exp_hit = 16'd4;
    exp_tc  = 32'd7;
    for (int k = 0; k < 5; k++) begin
      step_halt($sformatf("step%0d", k), 32'(k), 2'd2);
    end

    // Step plus an enabled entry on the same id reports both causes.
    drive(1'b0, 32'd0, 1'b1, 3'd0, 32'h2, 1'b1, 1'b0, 1'b0);
    tick();
    step_halt("bp_step", 32'h2, 2'd3);

    // Preload counters near their limits, then saturate hit_count and wrap trace_count.
    drive(1'b0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    force dut.hit_cnt_q   = 16'hFFFD;
    force dut.trace_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt_q;
    release dut.trace_cnt_q;
    exp_hit = 16'hFFFD;
    exp_tc  = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      step_halt($sformatf("sat%0d", k), 32'h10 + 32'(k), 2'd2);
    end

    // Asynchronous reset while halted: everything clears before the next edge.
    drive(1'b1, 32'h20, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("pre_reset halted", 64'(halted), 64'd1);
    rst_n = 1'b0;
    #2;
    chk_all("async_reset", 1'b1, 1'b0, 32'h0, 3'd0, 2'd0, 16'd0, 32'd0);
    drive(1'b0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Previously programmed ids must no longer halt: table cleared.
    begin
      logic [31:0] ids [5];
      ids[0] = 32'h5; ids[1] = 32'h9; ids[2] = 32'h7; ids[3] = 32'h2; ids[4] = 32'h0;
      for (int k = 0; k < 5; k++) begin
        drive(1'b1, ids[k], 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all($sformatf("post_reset%0d", k), 1'b1, 1'b0, 32'h0, 3'd0, 2'd0, 16'd0, 32'(k + 1));
      end
    end
    drive(1'b0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
